// File: rtl/pito_loader_pkg.sv
// rtl/pito_loader_pkg.sv - shared state encoding and stream framing constants for the imem loader.
package pito_loader_pkg;

  typedef enum logic [2:0] {HDR, DATA, CSUM, DONE, ERR} loader_state_e;

  localparam int LOADER_HDR_BYTES  = 4;
  localparam int LOADER_WORD_BYTES = 4;

endpackage

// File: rtl/pito_byte_assembler.sv
// rtl/pito_byte_assembler.sv - packs little-endian bytes into 32-bit words; word_valid pulses with the 4th byte.
module pito_byte_assembler
  import pito_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_LANE = 2'(LOADER_WORD_BYTES - 1);

  logic [1:0]  r_lane;
  logic [23:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lane  <= 2'd0;
      r_shift <= 24'd0;
    end else if (clear) begin
      r_lane  <= 2'd0;
    end else if (i_valid) begin
      r_lane  <= r_lane + 2'd1;
      r_shift <= {i_data, r_shift[23:8]};
    end
  end

  // Word is presented in the same cycle as its last byte so the top can register the write directly.
  assign o_word_valid = i_valid && (r_lane == LAST_LANE);
  assign o_word       = {i_data, r_shift};

endmodule

// File: rtl/pito_imem_loader.sv
// rtl/pito_imem_loader.sv - boot loader writing a byte-streamed image into imem; PITO_LOADER_CHECKSUM_EN adds a trailing checksum.
module pito_imem_loader
  import pito_loader_pkg::*;
#(
  parameter  int IMEM_DEPTH = 4096,
  localparam int ADDR_W     = $clog2(IMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic              error
);

  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  loader_state_e     r_state;
  logic [ADDR_W:0]   r_widx;
  logic [ADDR_W:0]   r_last;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_core_rst_n;
  logic              r_done;
  logic              r_err;
`ifdef PITO_LOADER_CHECKSUM_EN
  logic [31:0]       r_csum;
`endif

  logic        w_fire;
  logic        w_word_valid;
  logic [31:0] w_word;

  assign s_ready = (r_state == HDR) || (r_state == DATA) || (r_state == CSUM);
  assign w_fire  = s_valid && s_ready && !clear;

  pito_byte_assembler u_asm (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .i_valid      (w_fire),
    .i_data       (s_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= HDR;
      r_widx       <= '0;
      r_last       <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= 32'd0;
      r_core_rst_n <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
`ifdef PITO_LOADER_CHECKSUM_EN
      r_csum       <= 32'd0;
`endif
    end else begin
      r_we <= 1'b0;
      if (clear) begin
        r_state      <= HDR;
        r_widx       <= '0;
        r_addr       <= '0;
        r_wdata      <= 32'd0;
        r_core_rst_n <= 1'b0;
        r_done       <= 1'b0;
        r_err        <= 1'b0;
`ifdef PITO_LOADER_CHECKSUM_EN
        r_csum       <= 32'd0;
`endif
      end else begin
        case (r_state)
          HDR: if (w_word_valid) begin
            if (w_word > 32'(IMEM_DEPTH)) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else if (w_word == 32'd0) begin
`ifdef PITO_LOADER_CHECKSUM_EN
              r_state <= CSUM;
`else
              r_state <= DONE;
              r_done  <= 1'b1;
`endif
            end else begin
              // Store N-1 so the last-word test is a plain equality on the index.
              r_last  <= w_word[ADDR_W:0] - IDX_ONE;
              r_state <= DATA;
            end
          end
          DATA: if (w_word_valid) begin
            r_we    <= 1'b1;
            r_addr  <= r_widx[ADDR_W-1:0];
            r_wdata <= w_word;
            r_widx  <= r_widx + IDX_ONE;
`ifdef PITO_LOADER_CHECKSUM_EN
            r_csum  <= r_csum + w_word;
            if (r_widx == r_last) r_state <= CSUM;
`else
            if (r_widx == r_last) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
`endif
          end
`ifdef PITO_LOADER_CHECKSUM_EN
          CSUM: if (w_word_valid) begin
            if (w_word == r_csum) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end
          end
`endif
          // Releasing the core one cycle after done guarantees the final write has landed.
          DONE: r_core_rst_n <= 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst_n = r_core_rst_n;
  assign done       = r_done;
  assign error      = r_err;

endmodule

// File: tb/tb_pito_imem_loader.sv
// tb/tb_pito_imem_loader.sv - scoreboard bench for pito_imem_loader with random images and gaps.
module tb_pito_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = $clog2(DEPTH);
`ifdef PITO_LOADER_CHECKSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          s_valid = 1'b0;
  logic [7:0]    s_data = 8'd0;
  logic          s_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          done;
  logic          error;

  pito_imem_loader #(.IMEM_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst_n (core_rst_n),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  wr_t         exp_q[$];
  logic [31:0] img[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: addr %h data %h with no write expected", imem_addr, imem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(imem_addr), 32'(e.addr));
        chk("wr_data", imem_wdata, e.data);
      end
    end
  end

  function automatic logic [31:0] img_sum();
    logic [31:0] s = 32'd0;
    foreach (img[i]) s += img[i];
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_max);
    int g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
    repeat (g) tick();
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap_max);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gap_max);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 32'(s_ready), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_we"}, 32'(imem_we), 32'd0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_idle("clear");
  endtask

  task automatic check_reset_vals(input string tag);
    check_idle(tag);
    chk({tag, "_addr"}, 32'(imem_addr), 32'd0);
    chk({tag, "_wdata"}, imem_wdata, 32'd0);
  endtask

  // Reference: an image is accepted iff N fits and (if enabled) the checksum equals the word sum.
  task automatic run_load(input logic [31:0] n, input logic [31:0] csum_val, input int gap, input string tag);
    bit ok;
    if (n > DEPTH) begin
      send_word(n, gap);
      chk({tag, "_error"}, 32'(error), 32'd1);
      chk({tag, "_ready"}, 32'(s_ready), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      tick();
      tick();
      chk({tag, "_core_held"}, 32'(core_rst_n), 32'd0);
      return;
    end
    ok = !CSUM_ON || (csum_val == img_sum());
    for (int i = 0; i < int'(n); i++) exp_q.push_back({AW'(i), img[i]});
    send_word(n, gap);
    if (n != 0) chk({tag, "_busy_after_hdr"}, 32'(done), 32'd0);
    for (int i = 0; i < int'(n); i++) send_word(img[i], gap);
`ifdef PITO_LOADER_CHECKSUM_EN
    send_word(csum_val, gap);
`endif
    chk({tag, "_done"}, 32'(done), ok ? 32'd1 : 32'd0);
    chk({tag, "_error"}, 32'(error), ok ? 32'd0 : 32'd1);
    chk({tag, "_core_early"}, 32'(core_rst_n), 32'd0);
    chk({tag, "_ready_end"}, 32'(s_ready), 32'd0);
    tick();
    chk({tag, "_core_rst_n"}, 32'(core_rst_n), ok ? 32'd1 : 32'd0);
    tick();
    chk({tag, "_writes_seen"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] n;

    repeat (3) tick();
    check_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    img = '{32'h0000_0013, 32'h0010_0093};
    run_load(2, 32'h0010_00A6, 0, "fixed");
`ifdef PITO_LOADER_CHECKSUM_EN
    do_clear();
    run_load(2, 32'h0010_00A7, 0, "bad_csum");
`endif

    do_clear();
    img.delete();
    run_load(DEPTH + 1, 32'd0, 1, "oversize");

    do_clear();
    img.delete();
    run_load(0, 32'd0, 0, "zero");

    for (int k = 0; k < 4; k++) begin
      do_clear();
      img.delete();
      n = $urandom_range(20, 1);
      for (int i = 0; i < int'(n); i++) img.push_back($urandom);
      run_load(n, img_sum(), 3, "rand");
    end

    do_clear();
    img.delete();
    for (int i = 0; i < DEPTH; i++) img.push_back($urandom);
    run_load(DEPTH, img_sum(), 2, "full");

    do_clear();
    w0 = $urandom;
    exp_q.push_back({AW'(0), w0});
    send_word(32'd3, 0);
    send_word(w0, 0);
    send_byte(8'h5A, 0);
    send_byte(8'hC3, 0);
    s_valid = 1'b1;
    s_data  = 8'hFF;
    clear   = 1'b1;
    tick();
    s_valid = 1'b0;
    clear   = 1'b0;
    check_idle("mid_clear");
    tick();
    chk("mid_clear_writes", 32'(exp_q.size()), 32'd0);
    img = '{$urandom};
    run_load(1, img_sum(), 1, "after_clear");

    do_clear();
    w0 = $urandom | 32'h1;
    exp_q.push_back({AW'(0), w0});
    send_word(32'd4, 0);
    send_word(w0, 0);
    send_byte(8'h77, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    tick();
    chk("async_rst_writes", 32'(exp_q.size()), 32'd0);
    img = '{$urandom};
    run_load(1, img_sum(), 0, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
